// File: rtl/reset_seq_gen.sv
// reset_seq_gen: stretches POR/SW/WDT resets and releases NUM_DOMAINS domains in staggered order.
// Define RESET_SEQ_GEN_SW_REQ_SYNC_EN to treat sw_req as asynchronous (2-flop sync + rising-edge detect).
module reset_seq_gen #(
  parameter int SYNC_STAGES       = 2,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int NUM_DOMAINS       = 4,
  parameter int RELEASE_GAP       = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sw_req,
  input  logic                   wdt_expire,
  output logic [NUM_DOMAINS-1:0] reset,
  output logic [NUM_DOMAINS-1:0] reset_n_out,
  output logic                   busy,
  output logic                   sw_ack,
  output logic [1:0]             cause
);
  localparam int MAXC = MIN_ASSERT_CYCLES > RELEASE_GAP ? MIN_ASSERT_CYCLES : RELEASE_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [NUM_DOMAINS-1:0] r_reset;
  logic [NUM_DOMAINS-1:0] w_rel;
  logic                   r_busy;
  logic                   r_sw_ack;
  logic                   r_sw_pend;
  logic [1:0]             r_cause;
  logic                   w_sync;
  logic                   w_sw_req;
  logic                   w_step;
  assign w_sync = r_sync[SYNC_STAGES-1];
  // clearing the lowest set bit releases domains strictly in index order
  assign w_rel  = r_reset & (r_reset - NUM_DOMAINS'(1));
  assign w_step = r_cnt == CW'(r_state == HOLD ? MIN_ASSERT_CYCLES - 1 : RELEASE_GAP - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end
`ifdef RESET_SEQ_GEN_SW_REQ_SYNC_EN
  logic [2:0] r_sw_sync;
  logic       r_sw_pulse;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_sync  <= '0;
      r_sw_pulse <= 1'b0;
    end else begin
      r_sw_sync  <= {r_sw_sync[1:0], sw_req};
      r_sw_pulse <= r_sw_sync[1] & ~r_sw_sync[2];
    end
  end
  assign w_sw_req = r_sw_pulse;
`else
  assign w_sw_req = sw_req;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_reset   <= '1;
      r_busy    <= 1'b1;
      r_sw_ack  <= 1'b0;
      r_sw_pend <= 1'b0;
      r_cause   <= 2'd0;
    end else begin
      r_sw_ack <= 1'b0;
      if (wdt_expire) begin
        r_state   <= HOLD;
        r_cnt     <= '0;
        r_reset   <= '1;
        r_busy    <= 1'b1;
        r_sw_pend <= 1'b0;
        r_cause   <= 2'd2;
      end else if (r_state == RUN) begin
        if (w_sw_req) begin
          r_state   <= HOLD;
          r_cnt     <= '0;
          r_reset   <= '1;
          r_busy    <= 1'b1;
          r_sw_pend <= 1'b1;
          r_cause   <= 2'd1;
        end
      end else if (w_sync) begin
        if (w_step) begin
          r_cnt   <= '0;
          r_reset <= w_rel;
          if (w_rel == '0) begin
            r_state   <= RUN;
            r_busy    <= 1'b0;
            r_sw_ack  <= r_sw_pend;
            r_sw_pend <= 1'b0;
          end else begin
            r_state <= RELEASE;
          end
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end
  assign reset       = r_reset;
  assign reset_n_out = ~r_reset;
  assign busy        = r_busy;
  assign sw_ack      = r_sw_ack;
  assign cause       = r_cause;
endmodule

// File: tb/tb_reset_seq_gen.sv
// tb_reset_seq_gen: scoreboard bench driving a default-parameter and a corner-parameter reset_seq_gen.
// Expected outputs come from a release-time model keyed on the absolute edge index.
module tb_reset_seq_gen;
  localparam int GAP = 4;
  localparam int S0 = 2, M0 = 16, N0 = 4;
  localparam int S1 = 3, M1 = 1, N1 = 1;
`ifdef RESET_SEQ_GEN_SW_REQ_SYNC_EN
  localparam bit SW_SYNC = 1'b1;
`else
  localparam bit SW_SYNC = 1'b0;
`endif
  typedef struct packed {
    logic [3:0] rst;
    logic       busy;
    logic       ack;
    logic [1:0] cause;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sw_req = 1'b0;
  logic       wdt_expire = 1'b0;
  logic [3:0] rst0, rstn0;
  logic [0:0] rst1, rstn1;
  logic       busy0, busy1, ack0, ack1;
  logic [1:0] cause0, cause1;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         m_start [2];
  bit         m_wait [2];
  bit         m_pend [2];
  logic [1:0] m_cause [2];
  logic [3:0] sw_h = '0;
  exp_t       sb0 [$];
  exp_t       sb1 [$];
  reset_seq_gen #(.SYNC_STAGES(S0), .MIN_ASSERT_CYCLES(M0), .NUM_DOMAINS(N0), .RELEASE_GAP(GAP)) u_main (
    .clk(clk), .reset_n(reset_n), .sw_req(sw_req), .wdt_expire(wdt_expire),
    .reset(rst0), .reset_n_out(rstn0), .busy(busy0), .sw_ack(ack0), .cause(cause0)
  );
  reset_seq_gen #(.SYNC_STAGES(S1), .MIN_ASSERT_CYCLES(M1), .NUM_DOMAINS(N1), .RELEASE_GAP(GAP)) u_corner (
    .clk(clk), .reset_n(reset_n), .sw_req(sw_req), .wdt_expire(wdt_expire),
    .reset(rst1), .reset_n_out(rstn1), .busy(busy1), .sw_ack(ack1), .cause(cause1)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask
  function automatic exp_t model_out(input int d, input int t);
    exp_t e;
    int mn, nd, last;
    mn = d == 0 ? M0 : M1;
    nd = d == 0 ? N0 : N1;
    e = '0;
    e.cause = m_cause[d];
    if (m_wait[d]) begin
      e.rst  = d == 0 ? 4'hF : 4'h1;
      e.busy = 1'b1;
      return e;
    end
    last = m_start[d] + mn + (nd - 1) * GAP;
    for (int k = 0; k < nd; k++) e.rst[k] = t < m_start[d] + mn + k * GAP;
    e.busy = t < last;
    e.ack  = (t == last) && m_pend[d];
    return e;
  endfunction
  always @(posedge clk) begin
    logic eff_sw;
    int last;
    cyc++;
    eff_sw = SW_SYNC ? (sw_h[2] & ~sw_h[3]) : sw_req;
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        m_wait[d]  = 1'b1;
        m_cause[d] = 2'd0;
        m_pend[d]  = 1'b0;
      end else if (m_wait[d]) begin
        m_wait[d]  = 1'b0;
        m_start[d] = cyc + (d == 0 ? S0 : S1) - 1;
      end else begin
        last = m_start[d] + (d == 0 ? M0 + (N0 - 1) * GAP : M1 + (N1 - 1) * GAP);
        if (wdt_expire) begin
          m_start[d] = cyc;
          m_cause[d] = 2'd2;
          m_pend[d]  = 1'b0;
        end else if (eff_sw && cyc > last) begin
          m_start[d] = cyc;
          m_cause[d] = 2'd1;
          m_pend[d]  = 1'b1;
        end
      end
    end
    sw_h = reset_n ? {sw_h[2:0], sw_req} : 4'h0;
    sb0.push_back(model_out(0, cyc));
    sb1.push_back(model_out(1, cyc));
  end
  // an asynchronous assertion replaces the expectation already queued for this cycle
  always @(negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      m_wait[d]  = 1'b1;
      m_cause[d] = 2'd0;
      m_pend[d]  = 1'b0;
    end
    sw_h = '0;
    if (sb0.size() > 0) sb0[sb0.size()-1] = model_out(0, cyc);
    if (sb1.size() > 0) sb1[sb1.size()-1] = model_out(1, cyc);
  end
  always @(negedge clk) begin
    exp_t e0, e1;
    if (sb0.size() != 1 || sb1.size() != 1) begin
      check("sb_depth", 4'(sb0.size() + sb1.size()), 4'd2);
      sb0.delete();
      sb1.delete();
    end else begin
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      check("rst0", rst0, e0.rst);
      check("rstn0", rstn0, ~e0.rst);
      check("busy0", {3'b0, busy0}, {3'b0, e0.busy});
      check("ack0", {3'b0, ack0}, {3'b0, e0.ack});
      check("cause0", {2'b0, cause0}, {2'b0, e0.cause});
      check("rst1", {3'b0, rst1}, {3'b0, e1.rst[0]});
      check("rstn1", {3'b0, rstn1}, {3'b0, ~e1.rst[0]});
      check("busy1", {3'b0, busy1}, {3'b0, e1.busy});
      check("ack1", {3'b0, ack1}, {3'b0, e1.ack});
      check("cause1", {2'b0, cause1}, {2'b0, e1.cause});
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic pulse(input bit sw, input bit wdt);
    sw_req     = sw;
    wdt_expire = wdt;
    step(1);
    sw_req     = 1'b0;
    wdt_expire = 1'b0;
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      m_wait[d]  = 1'b1;
      m_pend[d]  = 1'b0;
      m_cause[d] = 2'd0;
      m_start[d] = 0;
    end
    step(5);
    #1 reset_n = 1'b1;
    step(40);
    pulse(1'b1, 1'b0);
    step(40);
    pulse(1'b1, 1'b0);
    step(16);
    pulse(1'b0, 1'b1);
    step(50);
    pulse(1'b1, 1'b1);
    step(5);
    pulse(1'b1, 1'b0);
    step(40);
    pulse(1'b1, 1'b0);
    step(20);
    reset_n = 1'b0;
    step(3);
    #1 reset_n = 1'b1;
    step(40);
    sw_req = 1'b1;
    step(10);
    sw_req = 1'b0;
    step(40);
    for (int i = 0; i < 8; i++) begin
      pulse($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      step($urandom_range(1, 35));
    end
    step(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
